inv_key_schedule: RTL

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/inv_key_schedule_sub_word.sv | 11 +
 rtl/inv_key_schedule.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES tables, GF(2^8) helpers and the FSM state type shared by the key schedule.
// The InvMixColumns output stage of inv_key_schedule is enabled with INV_KEY_MIXCOL_EN.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        SERVE
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 is never used: the first Rcon application is at i = Nk.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_key_schedule_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/inv_key_schedule.sv
// AES key expansion, one word per cycle, then serves round keys Nr down to 0.
// Define INV_KEY_MIXCOL_EN to apply InvMixColumns to rounds 1..Nr-1.
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:Nk*32-1]  key,
    input  logic              start,
    output logic              busy,
    output logic [0:127]      rk,
    output logic [3:0]        rk_round,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic              done
);

    localparam int         NW       = 4 * (Nr + 1);
    localparam logic [5:0] LAST_IDX = 6'(NW - 1);
    localparam logic [5:0] NK_W     = 6'(Nk);
    localparam logic [3:0] NR_W     = 4'(Nr);

    state_e       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   pos_q, pos_d;
    logic [3:0]   rcon_idx_q, rcon_idx_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rk_q, rk_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  w_q [NW];
    logic [Nk*32-1:0] key_flat;
    logic [31:0]  prev_w, back_w, sub_in, sub_out, temp, new_w;
    logic [3:0]   nxt_round;
    logic [5:0]   base;
    logic [127:0] entry_key, srv_raw, srv_key;

`ifdef INV_KEY_MIXCOL_EN
    function automatic logic [31:0] inv_mix_word(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction
`endif

    assign key_flat = key;

    // pos_q tracks i mod Nk and rcon_idx_q tracks i / Nk, avoiding a divider.
    assign prev_w = w_q[idx_q - 6'd1];
    assign back_w = w_q[idx_q - NK_W];
    assign sub_in = (pos_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    sub_word u_sub_word (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        if (pos_q == '0)
            temp = sub_out ^ {RCON[rcon_idx_q], 24'h0};
        else if (Nk == 8 && pos_q == 3'd4)
            temp = sub_out;
        else
            temp = prev_w;
    end

    assign new_w = back_w ^ temp;

    // Round Nr includes the word being written on the entry edge.
    assign entry_key = {w_q[NW-4], w_q[NW-3], w_q[NW-2], new_w};
    assign nxt_round = round_q - 4'd1;
    assign base      = {nxt_round, 2'b00};
    assign srv_raw   = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};

`ifdef INV_KEY_MIXCOL_EN
    assign srv_key = (nxt_round != '0)
                   ? {inv_mix_word(srv_raw[127:96]), inv_mix_word(srv_raw[95:64]),
                      inv_mix_word(srv_raw[63:32]),  inv_mix_word(srv_raw[31:0])}
                   : srv_raw;
`else
    assign srv_key = srv_raw;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        rcon_idx_d = rcon_idx_q;
        round_d    = round_q;
        rk_d       = rk_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = EXPAND;
                    idx_d      = NK_W;
                    pos_d      = '0;
                    rcon_idx_d = 4'd1;
                end
            end
            EXPAND: begin
                idx_d = idx_q + 6'd1;
                if (pos_q == 3'(Nk - 1)) begin
                    pos_d      = '0;
                    rcon_idx_d = rcon_idx_q + 4'd1;
                end else begin
                    pos_d = pos_q + 3'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d    = SERVE;
                    round_d    = NR_W;
                    rk_d       = entry_key;
                    rk_valid_d = 1'b1;
                end
            end
            SERVE: begin
                if (rk_ready) begin
                    if (round_q == '0) begin
                        state_d    = IDLE;
                        rk_valid_d = 1'b0;
                        rk_d       = '0;
                        done_d     = 1'b1;
                    end else begin
                        round_d = nxt_round;
                        rk_d    = srv_key;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pos_q      <= '0;
            rcon_idx_q <= '0;
            round_q    <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            rcon_idx_q <= rcon_idx_d;
            round_q    <= round_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            for (int unsigned j = 0; j < Nk; j++)
                w_q[j] <= key_flat[(Nk - 1 - j) * 32 +: 32];
        end else if (state_q == EXPAND) begin
            w_q[idx_q] <= new_w;
        end
    end

    assign busy     = busy_q;
    assign rk       = rk_q;
    assign rk_round = round_q;
    assign rk_valid = rk_valid_q;
    assign done     = done_q;

endmodule
